// File: rtl/bus_phase_sequencer.sv
// Byte-serial bus sequencer: round-robin arbitration between two requesters,
// then address / write-data / turnaround / read-data byte phases on an 8-bit bus.
module bus_phase_sequencer #(
  parameter int TURN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic [7:0]  bus_out,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_in,
  output logic        bus_sync,
  output logic        bus_we
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        gnt, gnt_nx, last_gnt;
  logic [31:0] a_lat, w_lat;
  logic        we_lat;
  logic [23:0] rsh;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      a_lat    <= '0;
      w_lat    <= '0;
      we_lat   <= 1'b0;
      rsh      <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 3'd0 : cnt + 3'd1;
      if (state == S_IDLE && (req0 || req1)) begin
        gnt      <= gnt_nx;
        last_gnt <= gnt_nx;
        a_lat    <= gnt_nx ? addr1  : addr0;
        w_lat    <= gnt_nx ? wdata1 : wdata0;
        we_lat   <= gnt_nx ? we1    : we0;
      end
      // Bytes arrive LSB first; the fourth byte completes the word in one update.
      if (state == S_RDATA) begin
        if (cnt == 3'd3) rdata <= {bus_in, rsh};
        else             rsh   <= {bus_in, rsh[23:8]};
      end
    end
  end

  always_comb begin
    state_nx = state;
    bus_out  = 8'h00;
    bus_oe   = 8'h00;
    bus_sync = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    gnt_nx   = (req0 && req1) ? ~last_gnt : req1;
    case (state)
      S_IDLE:  if (req0 || req1) state_nx = S_ADDR;
      S_ADDR: begin
        bus_oe   = 8'hFF;
        bus_sync = (cnt == 3'd0);
        bus_out  = sel_byte(a_lat, cnt[1:0]);
        if (cnt == 3'd3) state_nx = we_lat ? S_WDATA : S_TURN;
      end
      S_WDATA: begin
        bus_oe  = 8'hFF;
        bus_out = sel_byte(w_lat, cnt[1:0]);
        if (cnt == 3'd3) state_nx = S_DONE;
      end
      S_TURN:  if (cnt == 3'(TURN - 1)) state_nx = S_RDATA;
      S_RDATA: if (cnt == 3'd3) state_nx = S_DONE;
      S_DONE: begin
        done0    = ~gnt;
        done1    = gnt;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus_we = (state != S_IDLE) && we_lat;

endmodule

// File: tb/tb_bus_phase_sequencer.sv
// Directed bench for bus_phase_sequencer: write/read byte phases, arbitration,
// async reset abort, latching of request fields and rdata hold.
module tb_bus_phase_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1;
  logic [31:0] rdata;
  logic [7:0]  bus_out, bus_oe, bus_in;
  logic        bus_sync, bus_we;

  int passed = 0;
  int total  = 0;

  bus_phase_sequencer #(.TURN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1), .done0(done0), .done1(done1), .rdata(rdata),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .bus_sync(bus_sync), .bus_we(bus_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wb [8];
    logic [7:0] rb [4];
    int nd;
    wb = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
    rb = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; bus_in = '0;
    #2 rst_n = 1'b0;
    step(); step();
    chk("rst_oe", bus_oe, 8'h00);
    chk("rst_out", bus_out, 8'h00);
    chk("rst_sync_we", {bus_sync, bus_we}, 2'b00);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // write from requester 0
    addr0 = 32'h12345678; wdata0 = 32'hCAFEBABE; we0 = 1; req0 = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t1_out", bus_out, wb[k-1]);
      chk("t1_oe", bus_oe, 8'hFF);
      chk("t1_sync", bus_sync, (k == 1));
      chk("t1_done_early", {done0, done1}, 2'b00);
      if (k == 1) chk("t1_we", bus_we, 1'b1);
    end
    step();
    chk("t1_done", {done0, done1}, 2'b10);
    req0 = 0;
    step();
    chk("t1_idle", {bus_oe, done0, done1, bus_we}, 11'h0);

    // read from requester 1, TURN = 1
    addr1 = 32'h000000A5; we1 = 0; req1 = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_addr", bus_out, (k == 1) ? 8'hA5 : 8'h00);
      chk("t2_oe", bus_oe, 8'hFF);
    end
    step();
    chk("t2_turn", {bus_oe, bus_out}, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_rd_oe", bus_oe, 8'h00);
      bus_in = rb[k];
      if (k == 3) chk("t2_rdata_hold", rdata, 32'h0);
    end
    step();
    chk("t2_done", {done0, done1}, 2'b01);
    chk("t2_rdata", rdata, 32'h44332211);
    req1 = 0;
    step();

    // write after read: rdata must survive a toggling bus_in
    addr0 = 32'h00000001; wdata0 = 32'h5A5A5A5A; we0 = 1; req0 = 1;
    for (int k = 1; k <= 9; k++) begin
      step();
      bus_in = 8'($urandom);
      chk("t3_rdata", rdata, 32'h44332211);
      if (k == 9) chk("t3_done", {done0, done1}, 2'b10);
    end
    req0 = 0;
    step();

    // fields changed and req dropped during ADDR
    addr0 = 32'hAABBCCDD; wdata0 = 32'h0; we0 = 1; req0 = 1;
    step();
    chk("t4_b0", bus_out, 8'hDD);
    addr0 = 32'h0; wdata0 = 32'hFFFFFFFF; we0 = 0; req0 = 0;
    for (int k = 2; k <= 9; k++) begin
      step();
      case (k)
        2: chk("t4_b1", bus_out, 8'hCC);
        3: chk("t4_b2", bus_out, 8'hBB);
        4: chk("t4_b3", bus_out, 8'hAA);
        9: chk("t4_done", {done0, done1}, 2'b10);
        default: chk("t4_wdata", bus_out, 8'h00);
      endcase
    end
    step();
    chk("t4_no_regrant", bus_oe, 8'h00);

    // both requesting from reset: grants alternate 0,1,0,1
    rst_n = 0;
    step();
    rst_n = 1;
    addr0 = 32'h100; addr1 = 32'h200; we0 = 1; we1 = 1; req0 = 1; req1 = 1;
    nd = 0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      step();
      if (done0 || done1) begin
        chk("t5_order", {done0, done1}, (nd % 2 == 0) ? 2'b10 : 2'b01);
        nd++;
      end
    end
    chk("t5_count", nd, 4);
    req0 = 0; req1 = 0;

    // async reset during WDATA aborts; req0 wins the tie afterwards
    rst_n = 0;
    step();
    rst_n = 1;
    addr0 = 32'h12345678; wdata0 = 32'hCAFEBABE; we0 = 1; req0 = 1;
    for (int k = 1; k <= 6; k++) step();
    chk("t6_wdata", {bus_oe, bus_out}, 16'hFFBA);
    rst_n = 0; req1 = 1; addr1 = 32'h99; we1 = 0;
    #1;
    chk("t6_async", {bus_oe, bus_out, bus_sync, bus_we, done0, done1}, 20'h0);
    step();
    chk("t6_no_done", {done0, done1, bus_oe}, 10'h0);
    rst_n = 1;
    step();
    chk("t6_regrant", bus_out, 8'h78);
    chk("t6_sync", bus_sync, 1'b1);
    for (int k = 2; k <= 9; k++) begin
      step();
      if (k == 9) chk("t6_done", {done0, done1}, 2'b10);
    end
    req0 = 0; req1 = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
